// File: rtl/ls193_timer_ctrl.sv
// ls193_timer_ctrl
//   Sequencer for a programmable interval timer built from cascaded
//   SN74LS193 up/down counters (WIDTH/4 chips, each /BO driving the next
//   chip's DOWN). It loads a reload value, generates DOWN pulses from clk
//   through a prescaler, and watches the top chip's /BO for terminal count.
//   At terminal count it raises a sticky irq. In one-shot mode it then
//   stops. In auto mode it reloads the same value and runs again.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     synchronous reset, active low
//   cpu_wr      command strobe, one cycle
//   cpu_cmd     00 CLEAR, 01 START one-shot, 10 START auto, 11 STOP
//   cpu_wdata   reload value N, sampled with START
//   irq_ack     clears irq and ovr
//   ctr_bo_n    /BO of the most-significant counter chip
//   ctr_clr     to all CLR pins
//   ctr_load_n  to all /LOAD pins
//   ctr_up      to UP of the least-significant chip, held high
//   ctr_down    to DOWN of the least-significant chip
//   ctr_data    to the D..A pins, bit 0 = chip 0 A
//   busy        sequencer not idle
//   irq         terminal count reached, sticky
//   ovr         terminal count reached while irq was already set, sticky
//
// State | meaning
//   CLR   | ctr_clr pulse, one cycle
//   IDLE  | waiting for a command
//   LOAD  | /LOAD held low for LOAD_CYC cycles
//   RUN   | prescaler generating DOWN pulses, /BO checked once per tick
//   TERM  | terminal count seen; reload (auto) or stop (one-shot)
module ls193_timer_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 16,
  parameter int LOAD_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_wr,
  input  logic [1:0]       cpu_cmd,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             irq_ack,
  input  logic             ctr_bo_n,
  output logic             ctr_clr,
  output logic             ctr_load_n,
  output logic             ctr_up,
  output logic             ctr_down,
  output logic [WIDTH-1:0] ctr_data,
  output logic             busy,
  output logic             irq,
  output logic             ovr
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PHALF = PW'(PRESCALE / 2);
  localparam logic [LW-1:0] LMAX  = LW'(LOAD_CYC - 1);

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_ONE   = 2'b01;
  localparam logic [1:0] CMD_AUTO  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [2:0] {
    S_CLR,
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_TERM
  } state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic [LW-1:0] lcnt;
  logic          auto_mode;

  // Count direction is always down; UP idles high so the chips see no up-edges.
  assign ctr_up  = 1'b1;
  assign pre_nxt = pre + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_CLR;
      ctr_clr    <= 1'b1;
      ctr_load_n <= 1'b1;
      ctr_down   <= 1'b0;
      ctr_data   <= '0;
      busy       <= 1'b1;
      irq        <= 1'b0;
      ovr        <= 1'b0;
      pre        <= '0;
      lcnt       <= '0;
      auto_mode  <= 1'b0;
    end else begin
      // Acknowledge first so a terminal count on the same edge overrides it.
      if (irq_ack) begin
        irq <= 1'b0;
        ovr <= 1'b0;
      end
      ctr_clr    <= 1'b0;
      ctr_load_n <= 1'b1;
      ctr_down   <= 1'b0;
      busy       <= 1'b1;

      case (state)
        S_CLR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_IDLE: begin
          busy <= 1'b0;
          if (cpu_wr) begin
            case (cpu_cmd)
              CMD_CLEAR: begin
                state   <= S_CLR;
                ctr_clr <= 1'b1;
                busy    <= 1'b1;
              end
              CMD_ONE, CMD_AUTO: begin
                state      <= S_LOAD;
                ctr_data   <= cpu_wdata;
                auto_mode  <= cpu_cmd[1];
                ctr_load_n <= 1'b0;
                lcnt       <= '0;
                busy       <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        S_LOAD: begin
          if (lcnt == LMAX) begin
            // The first DOWN rising edge coincides with entry into RUN.
            state    <= S_RUN;
            pre      <= '0;
            ctr_down <= 1'b1;
          end else begin
            lcnt       <= lcnt + LW'(1);
            ctr_load_n <= 1'b0;
          end
        end

        S_RUN: begin
          if (cpu_wr && cpu_cmd == CMD_CLEAR) begin
            state   <= S_CLR;
            ctr_clr <= 1'b1;
          end else if (cpu_wr && cpu_cmd == CMD_STOP) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (pre == PMAX) begin
            // DOWN is low in the second half of the tick, so /BO is settled.
            if (!ctr_bo_n) begin
              state <= S_TERM;
              irq   <= 1'b1;
              if (irq) ovr <= 1'b1;
            end else begin
              pre      <= '0;
              ctr_down <= 1'b1;
            end
          end else begin
            pre      <= pre_nxt;
            ctr_down <= (pre_nxt < PHALF);
          end
        end

        S_TERM: begin
          if (auto_mode) begin
            state      <= S_LOAD;
            ctr_load_n <= 1'b0;
            lcnt       <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= S_CLR;
          ctr_clr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ls193_timer_ctrl.sv
module tb_ls193_timer_ctrl;
  localparam int WIDTH    = 8;
  localparam int PRESCALE = 16;
  localparam int LOAD_CYC = 2;
  localparam int NCHIP    = WIDTH / 4;

  logic             clk;
  logic             reset_n;
  logic             cpu_wr;
  logic [1:0]       cpu_cmd;
  logic [WIDTH-1:0] cpu_wdata;
  logic             irq_ack;
  logic             ctr_bo_n;
  logic             ctr_clr;
  logic             ctr_load_n;
  logic             ctr_up;
  logic             ctr_down;
  logic [WIDTH-1:0] ctr_data;
  logic             busy;
  logic             irq;
  logic             ovr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  ls193_timer_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE), .LOAD_CYC(LOAD_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_wr(cpu_wr), .cpu_cmd(cpu_cmd),
    .cpu_wdata(cpu_wdata), .irq_ack(irq_ack), .ctr_bo_n(ctr_bo_n),
    .ctr_clr(ctr_clr), .ctr_load_n(ctr_load_n), .ctr_up(ctr_up),
    .ctr_down(ctr_down), .ctr_data(ctr_data), .busy(busy), .irq(irq), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cascade of '193 chips, counting down on DOWN rising edges.
  // Borrow ripples from chip 0 upward; the top /BO is low only when every
  // chip is zero and DOWN is low.
  logic [WIDTH-1:0] mcount = '0;
  logic             prev_down = 1'b0;
  int               down_pulses = 0;

  always @(negedge clk) begin
    logic       borrow;
    logic [3:0] nib;
    if (ctr_clr === 1'b1) begin
      mcount = '0;
    end else if (ctr_load_n === 1'b0) begin
      mcount = ctr_data;
    end else if (ctr_down === 1'b1 && prev_down === 1'b0) begin
      down_pulses++;
      borrow = 1'b1;
      for (int i = 0; i < NCHIP; i++) begin
        nib = mcount[4*i +: 4];
        if (borrow) begin
          borrow = (nib == 4'd0);
          nib    = nib - 4'd1;
        end
        mcount[4*i +: 4] = nib;
      end
    end
    prev_down = ctr_down;
  end

  assign ctr_bo_n = !((mcount == '0) && (ctr_down === 1'b0));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [WIDTH-1:0] data);
    cpu_wr    = 1'b1;
    cpu_cmd   = cmd;
    cpu_wdata = data;
    step();
    cpu_wr    = 1'b0;
  endtask

  // The command is presented during cycle 0; the sequencer reacts at cycle 1.
  task automatic start(input logic [1:0] cmd, input logic [WIDTH-1:0] data);
    cyc = 0;
    issue(cmd, data);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ovr(input int budget);
    int n = 0;
    while (ovr !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_cmd   = 2'b00;
    cpu_wdata = '0;
    irq_ack   = 1'b0;

    // 1. reset
    step(); step(); step();
    check("rst_clr",    {31'd0, ctr_clr},    32'd1);
    check("rst_load_n", {31'd0, ctr_load_n}, 32'd1);
    check("rst_up",     {31'd0, ctr_up},     32'd1);
    check("rst_down",   {31'd0, ctr_down},   32'd0);
    check("rst_data",   32'(ctr_data),       32'd0);
    check("rst_busy",   {31'd0, busy},       32'd1);
    check("rst_irq",    {31'd0, irq},        32'd0);
    check("rst_ovr",    {31'd0, ovr},        32'd0);
    reset_n = 1'b1;
    step();
    check("clr_fall",   {31'd0, ctr_clr},    32'd0);
    check("idle_busy",  {31'd0, busy},       32'd0);
    step();

    // 2. one-shot N=5: LOAD at cycles 1..2, irq at 2+5*16+1 = 83
    down_pulses = 0;
    start(2'b01, 8'd5);
    check("os_load_n",  {31'd0, ctr_load_n}, 32'd0);
    check("os_busy",    {31'd0, busy},       32'd1);
    check("os_data",    32'(ctr_data),       32'd5);
    wait_irq(200);
    check("os_irq_cyc", 32'(cyc),            32'd83);
    step();
    check("os_busy84",  {31'd0, busy},       32'd0);
    run_to(130);
    check("os_count",   32'(mcount),         32'd0);
    check("os_pulses",  32'(down_pulses),    32'd5);
    check("os_irq_hold",{31'd0, irq},        32'd1);
    check("os_ovr",     {31'd0, ovr},        32'd0);
    ack();
    check("os_ack",     {31'd0, irq},        32'd0);

    // 3. auto N=3: irq at 51, ovr at 102, ack at 110, irq again at 153
    start(2'b10, 8'd3);
    wait_irq(200);
    check("au_irq_cyc", 32'(cyc),            32'd51);
    check("au_ovr0",    {31'd0, ovr},        32'd0);
    wait_ovr(200);
    check("au_ovr_cyc", 32'(cyc),            32'd102);
    check("au_irq_set", {31'd0, irq},        32'd1);
    run_to(110);
    ack();
    check("au_ack_irq", {31'd0, irq},        32'd0);
    check("au_ack_ovr", {31'd0, ovr},        32'd0);
    wait_irq(200);
    check("au_irq2",    32'(cyc),            32'd153);

    // 6. ack coincident with the next terminal count (TERM at 204)
    run_to(160);
    ack();
    check("co_clear",   {31'd0, irq},        32'd0);
    run_to(203);
    ack();
    check("co_cyc",     32'(cyc),            32'd204);
    check("co_setwins", {31'd0, irq},        32'd1);
    check("co_ovr",     {31'd0, ovr},        32'd0);
    run_to(212);
    check("run_up",     {31'd0, ctr_up},     32'd1);
    issue(2'b01, 8'h99);
    check("st_ignored", 32'(ctr_data),       32'd3);
    check("st_busy",    {31'd0, busy},       32'd1);
    run_to(220);
    issue(2'b00, 8'h00);
    check("cl_pulse",   {31'd0, ctr_clr},    32'd1);
    step();
    check("cl_end",     {31'd0, ctr_clr},    32'd0);
    check("cl_busy",    {31'd0, busy},       32'd0);
    step();
    check("cl_count",   32'(mcount),         32'd0);
    ack();

    // 4. one-shot N=0 wraps: 256 ticks, irq at 2+256*16+1 = 4099
    down_pulses = 0;
    start(2'b01, 8'd0);
    wait_irq(5000);
    check("wr_irq_cyc", 32'(cyc),            32'd4099);
    step(); step();
    check("wr_pulses",  32'(down_pulses),    32'd256);
    check("wr_count",   32'(mcount),         32'd0);
    ack();

    // 5. STOP during the DOWN-high half of the first tick (cycle 8, p=5)
    down_pulses = 0;
    start(2'b01, 8'h40);
    run_to(8);
    check("sp_downhi",  {31'd0, ctr_down},   32'd1);
    issue(2'b11, 8'h00);
    check("sp_down0",   {31'd0, ctr_down},   32'd0);
    check("sp_busy",    {31'd0, busy},       32'd0);
    run_to(60);
    check("sp_count",   32'(mcount),         32'h3F);
    check("sp_pulses",  32'(down_pulses),    32'd1);
    check("sp_irq",     {31'd0, irq},        32'd0);

    // reset mid-run loses the pending irq
    start(2'b10, 8'd1);
    wait_irq(100);
    check("mr_irq",     {31'd0, irq},        32'd1);
    reset_n = 1'b0;
    step();
    check("mr_irq0",    {31'd0, irq},        32'd0);
    check("mr_clr",     {31'd0, ctr_clr},    32'd1);
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
